// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared branch condition codes, FSM states and predictor reset value
package control_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } brctrl_state_e;

  // Weakly not-taken
  localparam logic [1:0] BHT_RESET = 2'b01;

endpackage

// File: rtl/brcmp.sv
// rtl/brcmp.sv - conditional branch comparator, funct3-encoded
module brcmp
  import control_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      BR_EQ:   taken = (rs1 == rs2);
      BR_NE:   taken = (rs1 != rs2);
      BR_LT:   taken = ($signed(rs1) < $signed(rs2));
      BR_GE:   taken = ($signed(rs1) >= $signed(rs2));
      BR_LTU:  taken = (rs1 < rs2);
      BR_GEU:  taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolution, redirect/flush FSM, statistics and optional BHT (BRCTRL_BHT_EN)
module branch_ctrl
  import control_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int BHT_ENTRIES  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic        ex_pred_taken,
  input  logic        stall,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_if,
  output logic        flush_id,
  output logic        busy,
  output logic [31:0] cnt_branches,
  output logic [31:0] cnt_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  brctrl_state_e state, state_next;
  logic [2:0]    flush_cnt;
  logic          taken, predicted, resolve, mispredict;

  brcmp u_brcmp (
    .funct3 (ex_funct3),
    .rs1    (ex_rs1),
    .rs2    (ex_rs2),
    .taken  (taken)
  );

  // Branches seen during a redirect/flush are squashed, so only IDLE resolves
  assign resolve    = ex_valid & ex_is_branch & ~stall & (state == IDLE);
  assign mispredict = resolve & (taken ^ predicted);

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    case (state)
      IDLE:     if (mispredict) state_next = REDIRECT;
      REDIRECT: state_next = FLUSH;
      FLUSH:    if (flush_cnt == 3'(FLUSH_CYCLES - 1)) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (state != IDLE) begin
      busy     = 1'b1;
      flush_if = 1'b1;
      flush_id = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      flush_cnt       <= 3'd0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= 32'd0;
      cnt_branches    <= 32'd0;
      cnt_mispredicts <= 32'd0;
    end else begin
      state          <= state_next;
      flush_cnt      <= (state == FLUSH) ? flush_cnt + 3'd1 : 3'd0;
      redirect_valid <= mispredict;
      if (mispredict)
        redirect_pc <= taken ? ex_pc + ex_imm : ex_pc + 32'd4;
      if (resolve)
        cnt_branches <= cnt_branches + 32'd1;
      if (mispredict)
        cnt_mispredicts <= cnt_mispredicts + 32'd1;
    end
  end

`ifdef BRCTRL_BHT_EN
  logic [1:0] bht [BHT_ENTRIES];
  logic [IDX_W-1:0] upd_idx;
  logic unused_bht;

  assign upd_idx    = ex_pc[IDX_W+1:2];
  assign pred_taken = bht[if_pc[IDX_W+1:2]][1];
  assign predicted  = ex_pred_taken;
  assign unused_bht = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_RESET;
    end else if (resolve) begin
      if (taken && bht[upd_idx] != 2'b11)
        bht[upd_idx] <= bht[upd_idx] + 2'b01;
      else if (!taken && bht[upd_idx] != 2'b00)
        bht[upd_idx] <= bht[upd_idx] - 2'b01;
    end
  end
`else
  logic [31:0] unused_static;

  assign pred_taken    = 1'b0;
  assign predicted     = 1'b0;
  assign unused_static = {if_pc[31:1], ex_pred_taken} ^ 32'(IDX_W);
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_branch, ex_pred_taken, stall;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm, if_pc;
  logic        pred_taken, redirect_valid, flush_if, flush_id, busy;
  logic [31:0] redirect_pc, cnt_branches, cnt_mispredicts;

  int total = 0;
  int bad   = 0;

  branch_ctrl #(.FLUSH_CYCLES(2), .BHT_ENTRIES(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid        (ex_valid),
    .ex_is_branch    (ex_is_branch),
    .ex_funct3       (ex_funct3),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_pc           (ex_pc),
    .ex_imm          (ex_imm),
    .ex_pred_taken   (ex_pred_taken),
    .stall           (stall),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush_if        (flush_if),
    .flush_id        (flush_id),
    .busy            (busy),
    .cnt_branches    (cnt_branches),
    .cnt_mispredicts (cnt_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pt);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_funct3 = f3;
    ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_imm = imm; ex_pred_taken = pt;
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_funct3 = 3'd0;
    ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_pc = 32'd0; ex_imm = 32'd0;
    ex_pred_taken = 1'b0; stall = 1'b0; if_pc = 32'd0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_flush", {30'd0, flush_if, flush_id}, 32'd0);
    chk("rst_cnt_br", cnt_branches, 32'd0);
    chk("rst_cnt_mis", cnt_mispredicts, 32'd0);
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // BEQ taken, static not-taken prediction -> redirect to pc+imm
    branch(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    tick();
    chk("beq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("beq_redirect_pc", redirect_pc, 32'h120);
    chk("beq_flush_c1", {30'd0, flush_if, flush_id}, 32'd3);
    chk("beq_cnt_mis", cnt_mispredicts, 32'd1);
    // second mispredicting branch presented during flush must be ignored
    branch(3'b001, 32'd1, 32'd2, 32'h300, 32'h40, 1'b0);
    tick();
    chk("beq_pulse_one_cycle", {31'd0, redirect_valid}, 32'd0);
    chk("beq_flush_c2", {30'd0, flush_if, flush_id}, 32'd3);
    tick();
    chk("beq_flush_c3", {30'd0, flush_if, flush_id}, 32'd3);
    ex_valid = 1'b0;
    tick();
    chk("beq_flush_end", {30'd0, flush_if, flush_id}, 32'd0);
    chk("beq_busy_end", {31'd0, busy}, 32'd0);
    chk("busy_branch_ignored", cnt_branches, 32'd1);
    chk("busy_branch_no_mis", cnt_mispredicts, 32'd1);

    // BLT signed -1 < 1 taken; stall held through the flush
    branch(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF0, 1'b0);
    tick();
    ex_valid = 1'b0; stall = 1'b1;
    chk("blt_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("blt_redirect_pc", redirect_pc, 32'h1F0);
    chk("blt_cnt_br", cnt_branches, 32'd2);
    tick();
    chk("stall_busy_c2", {31'd0, busy}, 32'd1);
    tick();
    chk("stall_busy_c3", {31'd0, busy}, 32'd1);
    tick();
    chk("stall_busy_end", {31'd0, busy}, 32'd0);
    chk("stall_flush_end", {31'd0, flush_if}, 32'd0);
    stall = 1'b0;

    // BLTU 0xFFFFFFFF < 1 is false -> correct static prediction
    branch(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'h10, 1'b0);
    tick();
    ex_valid = 1'b0;
    chk("bltu_no_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("bltu_no_busy", {31'd0, busy}, 32'd0);
    chk("bltu_cnt_br", cnt_branches, 32'd3);
    chk("bltu_cnt_mis", cnt_mispredicts, 32'd2);

    // funct3 010 is never taken even with equal operands
    branch(3'b010, 32'd7, 32'd7, 32'h208, 32'h10, 1'b0);
    tick();
    ex_valid = 1'b0;
    chk("f010_no_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("f010_cnt_br", cnt_branches, 32'd4);

    // stalled branch not resolved, then resolves with wrapping target
    branch(3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b0);
    stall = 1'b1;
    tick();
    chk("stalled_not_counted", cnt_branches, 32'd4);
    chk("stalled_no_busy", {31'd0, busy}, 32'd0);
    stall = 1'b0;
    tick();
    ex_valid = 1'b0;
    chk("bne_wrap_pc", redirect_pc, 32'h10);
    chk("bne_cnt_mis", cnt_mispredicts, 32'd3);
    tick();
    chk("mid_flush_busy", {31'd0, busy}, 32'd1);

    // asynchronous reset in FLUSH
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_flush", {30'd0, flush_if, flush_id}, 32'd0);
    chk("arst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("arst_redirect_pc", redirect_pc, 32'd0);
    chk("arst_cnts", cnt_branches | cnt_mispredicts, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

`ifdef BRCTRL_BHT_EN
    if_pc = 32'h40;
    branch(3'b000, 32'd3, 32'd3, 32'h40, 32'h80, 1'b0);
    tick();
    ex_valid = 1'b0;
    chk("bht_first_mis", {31'd0, redirect_valid}, 32'd1);
    chk("bht_pred_after_1", {31'd0, pred_taken}, 32'd1);
    repeat (3) tick();
    branch(3'b000, 32'd3, 32'd3, 32'h40, 32'h80, 1'b1);
    tick();
    chk("bht_second_ok", {31'd0, redirect_valid}, 32'd0);
    tick();
    ex_valid = 1'b0;
    chk("bht_third_ok", {31'd0, redirect_valid}, 32'd0);
    chk("bht_pred_sat", {31'd0, pred_taken}, 32'd1);
    branch(3'b001, 32'd3, 32'd3, 32'h40, 32'h80, 1'b1);
    tick();
    ex_valid = 1'b0;
    chk("bht_nt_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("bht_nt_pc", redirect_pc, 32'h44);
    chk("bht_pred_11_to_10", {31'd0, pred_taken}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("bht_rst_pred", {31'd0, pred_taken}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
`else
    if_pc = 32'hFFFF_FFFC;
    #1;
    chk("static_pred_zero", {31'd0, pred_taken}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
